// File: rtl/wptr_full_gen_if.sv
// -----------------------------------------------------------------------------
// wptr_full_gen_if
// Write-domain bus of the async FIFO write-pointer / full-flag generator.
//   master : producer side (drives winc, wq2_rptr, clr_overflow)
//   slave  : wptr_full_gen (drives wen, waddr, wptr and the status flags)
// Signals:
//   winc         write request from the producer
//   wq2_rptr     Gray read pointer, already synchronized into the write clock
//   clr_overflow clears the sticky overflow flag
//   wen          memory write enable (combinational)
//   waddr        memory write address
//   wptr         registered Gray write pointer for the read-domain synchronizer
//   wfull        FIFO full
//   walmost_full fill level at or above the almost-full threshold
//   wlevel       write-side fill level, 0..depth
//   woverflow    sticky: a write was attempted while full
// -----------------------------------------------------------------------------
interface wptr_full_gen_if #(
  parameter int ADDR_WIDTH = 3
);
  logic                  winc;
  logic [ADDR_WIDTH:0]   wq2_rptr;
  logic                  clr_overflow;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH:0]   wptr;
  logic                  wfull;
  logic                  walmost_full;
  logic [ADDR_WIDTH:0]   wlevel;
  logic                  woverflow;

  modport master (
    output winc, wq2_rptr, clr_overflow,
    input  wen, waddr, wptr, wfull, walmost_full, wlevel, woverflow
  );

  modport slave (
    input  winc, wq2_rptr, clr_overflow,
    output wen, waddr, wptr, wfull, walmost_full, wlevel, woverflow
  );
endinterface

// File: rtl/wptr_full_gen.sv
// -----------------------------------------------------------------------------
// wptr_full_gen
// Write-domain pointer and full-flag generator for an async FIFO.
// Keeps a binary write pointer (addresses the memory) and its Gray image
// (crosses to the read domain), and derives full / almost-full / fill level /
// overflow from the read pointer synchronized into this clock.
// Ports:
//   clk  write-domain clock
//   rst  asynchronous, active-high reset
//   bus  wptr_full_gen_if.slave (see interface file for signal list)
// Parameters:
//   ADDR_WIDTH   memory address width (>= 2); depth = 2**ADDR_WIDTH
//   AFULL_THRESH fill level at or above which walmost_full asserts (1..depth)
// -----------------------------------------------------------------------------
module wptr_full_gen #(
  parameter int ADDR_WIDTH   = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic            clk,
  input  logic            rst,
  wptr_full_gen_if.slave  bus
);
  localparam int          PW      = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_L = PW'(AFULL_THRESH);

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_wlevel;
  logic          r_wfull;
  logic          r_walmost_full;
  logic          r_woverflow;

  logic          w_wen;
  logic          w_ovf_set;
  logic [PW-1:0] w_wbin_next;
  logic [PW-1:0] w_wgray_next;
  logic [PW-1:0] w_rbin_sync;
  logic [PW-1:0] w_level_next;
  logic [PW-1:0] w_full_gray;

  // Reset gates the enable so no memory write can slip through while the
  // pointers are being discarded.
  assign w_wen        = bus.winc & ~r_wfull & ~rst;
  assign w_ovf_set    = bus.winc & r_wfull;
  assign w_wbin_next  = r_wbin + PW'(w_wen);
  assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;

  // Gray-to-binary: bit i is the XOR of all Gray bits from the MSB down to i.
  // NOTE: every bit of a combinational output is assigned on every pass, so
  // no latch can be inferred.
  always_comb begin
    w_rbin_sync = '0;
    for (int i = 0; i < PW; i++) begin
      w_rbin_sync[i] = ^(bus.wq2_rptr >> i);
    end
  end

  assign w_level_next = w_wbin_next - w_rbin_sync;

  // The write pointer is exactly one lap ahead of the read pointer when its
  // Gray code equals the read Gray code with the top two bits inverted.
  assign w_full_gray = {~bus.wq2_rptr[PW-1:PW-2], bus.wq2_rptr[PW-3:0]};

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  // NOTE: all state is a handful of flops, so the asynchronous reset clears
  // every one of them; there is no memory array here to leave unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wbin         <= '0;
      r_wptr         <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
      r_wlevel       <= '0;
      r_woverflow    <= 1'b0;
    end else begin
      r_wbin         <= w_wbin_next;
      r_wptr         <= w_wgray_next;
      r_wfull        <= (w_wgray_next == w_full_gray);
      r_walmost_full <= (w_level_next >= AFULL_L);
      r_wlevel       <= w_level_next;
      // Set has priority over clear so a rejected write is never lost.
      r_woverflow    <= w_ovf_set | (r_woverflow & ~bus.clr_overflow);
    end
  end

  assign bus.wen          = w_wen;
  assign bus.waddr        = r_wbin[ADDR_WIDTH-1:0];
  assign bus.wptr         = r_wptr;
  assign bus.wfull        = r_wfull;
  assign bus.walmost_full = r_walmost_full;
  assign bus.wlevel       = r_wlevel;
  assign bus.woverflow    = r_woverflow;
endmodule

// File: tb/tb_wptr_full_gen.sv
// -----------------------------------------------------------------------------
// tb_wptr_full_gen
// Directed bench for wptr_full_gen (ADDR_WIDTH=3, AFULL_THRESH=6). A
// count-based model predicts every output each cycle; literal checks pin the
// model at the points of interest.
// -----------------------------------------------------------------------------
module tb_wptr_full_gen;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int MODP  = 2 * DEPTH;
  localparam int AF    = 6;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 0;

  wptr_full_gen_if #(.ADDR_WIDTH(AW)) bus ();

  wptr_full_gen #(.ADDR_WIDTH(AW), .AFULL_THRESH(AF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_wbin  = 0;   // writes accepted, modulo 2*depth
  int m_level = 0;
  bit m_full  = 0;
  bit m_afull = 0;
  bit m_ovf   = 0;

  function automatic int gray_to_int(input logic [AW:0] g);
    for (int i = 0; i < MODP; i++)
      if ((i ^ (i >> 1)) == int'(g)) return i;
    return -1;
  endfunction

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wbin = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0;
    end else begin
      bit acc;
      int rd;
      acc     = bus.winc && !m_full;
      m_ovf   = (bus.winc && m_full) || (m_ovf && !bus.clr_overflow);
      m_wbin  = (m_wbin + (acc ? 1 : 0)) % MODP;
      rd      = gray_to_int(bus.wq2_rptr);
      m_level = (m_wbin - rd + MODP) % MODP;
      m_full  = (m_level == DEPTH);
      m_afull = (m_level >= AF);
    end
  end

  task automatic compare_all();
    check("wen",          32'(bus.wen),          32'(bus.winc && !m_full && !rst));
    check("waddr",        32'(bus.waddr),        32'(m_wbin % DEPTH));
    check("wptr",         32'(bus.wptr),         32'(to_gray(m_wbin)));
    check("wfull",        32'(bus.wfull),        32'(m_full));
    check("walmost_full", 32'(bus.walmost_full), 32'(m_afull));
    check("wlevel",       32'(bus.wlevel),       32'(m_level));
    check("woverflow",    32'(bus.woverflow),    32'(m_ovf));
  endtask

  always @(posedge clk) begin
    #1;
    if (cmp_en) compare_all();
  end

  // Apply inputs at a falling edge and advance to the next falling edge.
  task automatic tick(input logic w, input logic c, input logic [AW:0] rp);
    bus.winc         = w;
    bus.clr_overflow = c;
    bus.wq2_rptr     = rp;
    @(negedge clk);
  endtask

  logic [AW:0] gray_tbl [0:8];

  initial begin
    gray_tbl[0] = 4'b0000; gray_tbl[1] = 4'b0001; gray_tbl[2] = 4'b0011;
    gray_tbl[3] = 4'b0010; gray_tbl[4] = 4'b0110; gray_tbl[5] = 4'b0111;
    gray_tbl[6] = 4'b0101; gray_tbl[7] = 4'b0100; gray_tbl[8] = 4'b1100;

    rst = 1'b0;
    bus.winc = 1'b0; bus.clr_overflow = 1'b0; bus.wq2_rptr = '0;
    #1 rst = 1'b1;
    cmp_en = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick(0, 0, 4'b0000);
    tick(0, 0, 4'b0000);
    check("idle_wptr",   32'(bus.wptr),   32'd0);
    check("idle_wlevel", 32'(bus.wlevel), 32'd0);
    check("idle_wfull",  32'(bus.wfull),  32'd0);

    // Reset mid-cycle with wbin=5
    repeat (5) tick(1, 0, 4'b0000);
    check("pre_rst_waddr", 32'(bus.waddr), 32'd5);
    #2 rst = 1'b1;
    #1;
    check("rst_wptr",      32'(bus.wptr),      32'd0);
    check("rst_waddr",     32'(bus.waddr),     32'd0);
    check("rst_wfull",     32'(bus.wfull),     32'd0);
    check("rst_wlevel",    32'(bus.wlevel),    32'd0);
    check("rst_woverflow", 32'(bus.woverflow), 32'd0);
    check("rst_wen",       32'(bus.wen),       32'd0);
    bus.winc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick(0, 0, 4'b0000);
    tick(0, 0, 4'b0000);
    check("post_rst_wptr",   32'(bus.wptr),   32'd0);
    check("post_rst_wlevel", 32'(bus.wlevel), 32'd0);

    // Fill to full
    for (int i = 0; i < DEPTH; i++) begin
      check("fill_waddr", 32'(bus.waddr), 32'(i));
      check("fill_wptr",  32'(bus.wptr),  32'(gray_tbl[i]));
      check("fill_afull", 32'(bus.walmost_full), 32'(i >= 6));
      tick(1, 0, 4'b0000);
    end
    check("full_wptr",   32'(bus.wptr),         32'(gray_tbl[8]));
    check("full_wfull",  32'(bus.wfull),        32'd1);
    check("full_wlevel", 32'(bus.wlevel),       32'd8);
    check("full_afull",  32'(bus.walmost_full), 32'd1);

    // Write while full
    bus.winc = 1'b1;
    #1 check("full_wen", 32'(bus.wen), 32'd0);
    repeat (3) tick(1, 0, 4'b0000);
    check("ovf_wptr_hold", 32'(bus.wptr),      32'b1100);
    check("ovf_set",       32'(bus.woverflow), 32'd1);
    tick(0, 1, 4'b0000);
    check("ovf_clear",     32'(bus.woverflow), 32'd0);
    tick(1, 1, 4'b0000);
    check("ovf_set_wins",  32'(bus.woverflow), 32'd1);
    check("ovf_wptr_hold2", 32'(bus.wptr),     32'b1100);

    // Release and wrap
    tick(0, 0, 4'b1100);
    check("rel_wfull",  32'(bus.wfull),  32'd0);
    check("rel_wlevel", 32'(bus.wlevel), 32'd0);
    repeat (8) tick(1, 0, 4'b1100);
    check("wrap_wptr",   32'(bus.wptr),   32'd0);
    check("wrap_waddr",  32'(bus.waddr),  32'd0);
    check("wrap_wfull",  32'(bus.wfull),  32'd1);
    check("wrap_wlevel", 32'(bus.wlevel), 32'd8);

    // Concurrent read/write
    rst = 1'b1;
    tick(0, 0, 4'b0000);
    rst = 1'b0;
    tick(1, 0, 4'b0000);
    repeat (4) tick(1, 0, 4'b0001);
    check("conc_setup_level", 32'(bus.wlevel), 32'd4);
    tick(1, 0, 4'b0011);
    check("conc_wlevel", 32'(bus.wlevel), 32'd4);
    check("conc_wfull",  32'(bus.wfull),  32'd0);
    check("conc_waddr",  32'(bus.waddr),  32'd6);

    // Almost-full boundary
    tick(1, 0, 4'b0011);
    check("af_level5",  32'(bus.wlevel),       32'd5);
    check("af_low",     32'(bus.walmost_full), 32'd0);
    tick(1, 0, 4'b0011);
    check("af_rise",    32'(bus.walmost_full), 32'd1);
    tick(0, 0, 4'b0010);
    check("af_fall",    32'(bus.walmost_full), 32'd0);
    check("af_level5b", 32'(bus.wlevel),       32'd5);

    tick(0, 0, 4'b0010);
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wptr_full_gen.md
Name: wptr_full_gen

Overview:
- Write-domain pointer and full-flag generator for the async FIFO.
- Produces the Gray-coded write pointer that the read domain double-flop synchronizes.
- Consumes the read pointer after it has been synchronized into the write domain.
- Produces the memory write address and write enable, plus full, almost-full, fill-level and overflow status, all in the write clock domain.

Parameters:
- ADDR_WIDTH, 3, memory address width. FIFO depth = 2**ADDR_WIDTH. Pointers are ADDR_WIDTH+1 bits.
- AFULL_THRESH, 6, fill level at or above which walmost_full asserts. Legal range 1..2**ADDR_WIDTH.

Ports:
- clk  input  1  write-domain clock. One clock only.
- rst  input  1  reset, asynchronous, active-high.
- winc  input  1  write request from the producer.
- wq2_rptr  input  ADDR_WIDTH+1  Gray read pointer, already synchronized into clk.
- clr_overflow  input  1  clears the woverflow sticky bit.
- wen  output  1  memory write enable, combinational.
- waddr  output  ADDR_WIDTH  memory write address.
- wptr  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer.
- wfull  output  1  FIFO full, registered.
- walmost_full  output  1  level >= AFULL_THRESH, registered.
- wlevel  output  ADDR_WIDTH+1  write-side fill level, registered, range 0..depth.
- woverflow  output  1  sticky flag: a write was attempted while full.

Behaviour:
- Reset: asynchronous, active-high.
  - While rst=1, all registers are cleared immediately, without waiting for a clock edge.
  - Cleared registers: wbin, wptr, wfull, walmost_full, wlevel and woverflow all read 0.
  - wen reads 0 while in reset.
- Write acceptance:
  - wen = winc & ~wfull & ~rst.
  - waddr = wbin[ADDR_WIDTH-1:0], the low bits of the registered binary pointer.
- Pointer update:
  - wbin_next = wbin + wen, modulo 2**(ADDR_WIDTH+1). No saturation; natural wrap.
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
  - wbin and wptr load wbin_next and wgray_next on every clk edge.
  - wptr changes by exactly one bit per accepted write and never glitches, because it is a register output.
- Full:
  - wfull <= (wgray_next == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]}), where MSB = ADDR_WIDTH.
  - Full asserts on the same edge that accepts the last free slot.
  - Full deasserts only after the read pointer has propagated through the synchronizer. This pessimistic release is required behaviour.
- Level:
  - rbin_sync is the Gray-to-binary conversion of wq2_rptr, via a prefix XOR from the MSB down.
  - wlevel <= wbin_next - rbin_sync, modulo 2**(ADDR_WIDTH+1).
  - walmost_full <= (wbin_next - rbin_sync) >= AFULL_THRESH.
- Overflow:
  - Set on any edge where winc=1 and wfull=1. The rejected write has no other effect: pointers hold and wen stays 0.
  - Cleared by clr_overflow=1.
  - If set and clear occur in the same cycle, set wins.
- Simultaneous events:
  - wq2_rptr advancing in the same cycle as an accepted write: both are used in the same next-state computation.
  - Full stays correct in this case.
  - wlevel is unchanged when one write is accepted and the read pointer advances by one in the same cycle.
- Wrap-around: the extra MSB distinguishes full from empty across pointer wrap. The pointer wraps from 2*depth-1 to 0 with no special case.
- Reset mid-operation: all state is discarded. The read side must be reset concurrently; this block does not enforce that.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst mid-cycle with wbin=5.
  - Required: wptr=0000, waddr=0, wfull=0, wlevel=0, woverflow=0 immediately, before the next clk edge.
  - Required: outputs stay 0 after release while winc=0.
- Fill to full:
  - Stimulus: wq2_rptr=0000, 8 consecutive winc cycles (ADDR_WIDTH=3).
  - Required: waddr steps 0..7, and wptr follows 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100.
  - Required: wfull=1 and wlevel=8 after the 8th edge.
  - Required: walmost_full=1 from the 6th edge.
- Write while full:
  - Stimulus: hold winc=1 for 3 cycles while full.
  - Required: wen=0, wptr holds 1100, woverflow=1.
  - Stimulus: pulse clr_overflow with winc=0. Required: woverflow=0.
  - Stimulus: clr_overflow=1 and winc=1 together while full. Required: woverflow stays 1.
- Release and wrap:
  - Stimulus: drive wq2_rptr=1100 (reads of 8 complete).
  - Required: wfull=0 and wlevel=0 on the next edge.
  - Stimulus: 8 more writes.
  - Required: wbin wraps to 0, wptr=0000, wfull=1, wlevel=8.
- Concurrent read/write:
  - Setup: level=4, wq2_rptr=0001.
  - Stimulus: winc=1 while wq2_rptr advances to 0011 in the same cycle.
  - Required: wlevel remains 4 and wfull=0.
- Almost-full boundary:
  - Stimulus: level 5, one write.
  - Required: walmost_full rises on that edge.
  - Stimulus: read pointer advances by one.
  - Required: walmost_full falls on the next edge.
